decoder_3x8_pipe: RTL and testbench



---
 rtl/decoder_pkg.sv | 30 +++
 rtl/decoder_skid_buf.sv | 75 +++++++
 rtl/decoder_3x8_pipe.sv | 66 ++++++
 tb/tb_decoder_3x8_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the streaming one-hot decoder.
// DECODER_PARITY_CHK_EN (optional) enables the input parity check in the top.
package decoder_pkg;

    localparam int unsigned DEC_N_DEF     = 3;
    localparam int unsigned DEC_OUT_W_DEF = 8;
    localparam int unsigned DEC_MAX_N     = 8;
    localparam int unsigned DEC_MAX_W     = 1 << DEC_MAX_N;
    localparam int unsigned DEC_PAR_W     = DEC_MAX_N + 1;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Widest decode; callers truncate to their own output width.
    function automatic logic [DEC_MAX_W-1:0] onehot_dec(input logic [DEC_MAX_N-1:0] code,
                                                        input logic en);
        logic [DEC_MAX_W-1:0] word;
        word = '0;
        if (en) word[code] = 1'b1;
        return word;
    endfunction

    function automatic logic even_par(input logic [DEC_PAR_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/decoder_skid_buf.sv
// Two-entry valid/ready skid buffer: output register O plus skid register S.
module decoder_skid_buf
    import decoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEC_OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] skid_q;
    logic             accept, drain, o_load, o_from_s, s_load;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        o_load   = 1'b0;
        o_from_s = 1'b0;
        s_load   = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d = SKID_ONE;
                    o_load  = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    o_load = 1'b1;
                end else if (accept) begin
                    state_d = SKID_FULL;
                    s_load  = 1'b1;
                end else if (drain) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    state_d  = SKID_ONE;
                    o_from_s = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // in_ready resets low so nothing is taken until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SKID_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d != SKID_FULL);
            out_valid <= (state_d != SKID_EMPTY);
            if (o_load)        out_data <= in_data;
            else if (o_from_s) out_data <= skid_q;
            if (s_load) skid_q <= in_data;
        end
    end

endmodule

// File: rtl/decoder_3x8_pipe.sv
// Streaming N-to-2^N one-hot decoder with valid/ready and a delivered-beat counter.
// Optional parity check on input beats under DECODER_PARITY_CHK_EN.
module decoder_3x8_pipe
    import decoder_pkg::*;
#(
    parameter int unsigned N     = DEC_N_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_code,
    input  logic                in_en,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [(1<<N)-1:0]   out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    beat_cnt
`ifdef DECODER_PARITY_CHK_EN
    ,
    input  logic                in_par,
    output logic                par_err
`endif
);

    localparam int unsigned OUT_W = 1 << N;

    logic [OUT_W-1:0] word_c;
    logic             buf_valid;

    assign word_c = OUT_W'(onehot_dec(DEC_MAX_N'(in_code), in_en));

`ifdef DECODER_PARITY_CHK_EN
    logic par_ok_c;

    assign par_ok_c  = (in_par == even_par(DEC_PAR_W'({in_en, in_code})));
    assign buf_valid = in_valid & par_ok_c;

    // A bad beat is still handshaken (consumed) but never enters the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err <= 1'b0;
        else     par_err <= in_valid & in_ready & ~par_ok_c;
    end
`else
    assign buf_valid = in_valid;
`endif

    decoder_skid_buf #(
        .WIDTH(OUT_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (word_c),
        .in_valid (buf_valid),
        .in_ready (in_ready),
        .out_data (out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        beat_cnt <= '0;
        else if (out_valid & out_ready) beat_cnt <= beat_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_decoder_3x8_pipe.sv
// Directed self-checking bench for decoder_3x8_pipe (round-trip parity section
// only when DECODER_PARITY_CHK_EN is defined).
module tb_decoder_3x8_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_code;
    logic        in_en;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] beat_cnt;
`ifdef DECODER_PARITY_CHK_EN
    logic        in_par;
    logic        par_err;
    logic        corrupt;
    assign in_par = (^{in_en, in_code}) ^ corrupt;
`endif

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    decoder_3x8_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_code  (in_code),
        .in_en    (in_en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .beat_cnt (beat_cnt)
`ifdef DECODER_PARITY_CHK_EN
        ,
        .in_par   (in_par),
        .par_err  (par_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

`ifdef DECODER_PARITY_CHK_EN
    function automatic logic [2:0] enc8x3(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int b = 0; b < 8; b++) if (onehot[b]) idx = 3'(b);
        return idx;
    endfunction
`endif

    initial begin
        rst = 1'b1; in_code = '0; in_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef DECODER_PARITY_CHK_EN
        corrupt = 1'b0;
`endif
        #3;
        check("rst_out", 32'(out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        #9 rst = 1'b0;
        #1 check("in_ready_before_edge", 32'(in_ready), 32'h0);
        edge_step();
        check("in_ready_after_edge", 32'(in_ready), 32'h1);

        // Back-to-back sweep with no backpressure.
        in_valid = 1'b1; in_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            edge_step();
            check($sformatf("sweep_out_%0d", i), 32'(out), 32'(sweep_exp[i]));
            check($sformatf("sweep_valid_%0d", i), 32'(out_valid), 32'h1);
            check($sformatf("sweep_cnt_%0d", i), 32'(beat_cnt), 32'(i));
        end
        in_valid = 1'b0;
        edge_step();
        check("sweep_cnt_final", 32'(beat_cnt), 32'd8);
        check("sweep_idle_valid", 32'(out_valid), 32'h0);

        // Enable low decodes to zero but is still a beat.
        in_valid = 1'b1; in_code = 3'd5; in_en = 1'b0;
        edge_step();
        check("en_low_out", 32'(out), 32'h0);
        check("en_low_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0; in_en = 1'b1;
        edge_step();
        check("en_low_cnt", 32'(beat_cnt), 32'd9);

        // Backpressure fills the skid register.
        out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd3;
        edge_step();
        check("bp_out_first", 32'(out), 32'h08);
        check("bp_ready_one", 32'(in_ready), 32'h1);
        in_code = 3'd6;
        edge_step();
        check("bp_ready_full", 32'(in_ready), 32'h0);
        check("bp_out_hold", 32'(out), 32'h08);
        in_code = 3'd7;
        edge_step();
        check("bp_stall_out", 32'(out), 32'h08);
        check("bp_stall_valid", 32'(out_valid), 32'h1);
        check("bp_stall_cnt", 32'(beat_cnt), 32'd9);
        in_valid = 1'b0; out_ready = 1'b1;
        edge_step();
        check("bp_drain_out", 32'(out), 32'h40);
        check("bp_drain_ready", 32'(in_ready), 32'h1);
        check("bp_drain_cnt", 32'(beat_cnt), 32'd10);
        edge_step();
        check("bp_empty_valid", 32'(out_valid), 32'h0);
        check("bp_empty_cnt", 32'(beat_cnt), 32'd11);

        // Async reset while FULL.
        out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd1;
        edge_step();
        in_code = 3'd2;
        edge_step();
        check("full_before_rst", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out", 32'(out), 32'h0);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_cnt", 32'(beat_cnt), 32'h0);
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        edge_step();
        check("post_rst_ready", 32'(in_ready), 32'h1);
        check("post_rst_valid", 32'(out_valid), 32'h0);
        edge_step();
        check("post_rst_no_stale", 32'(out_valid), 32'h0);
        check("post_rst_cnt", 32'(beat_cnt), 32'h0);

        // Counter wrap: 65535 transfers then one more.
        in_valid = 1'b1; in_code = 3'd0;
        repeat (65535) @(posedge clk);
        edge_step();
        check("wrap_ffff", 32'(beat_cnt), 32'h0000_ffff);
        edge_step();
        check("wrap_zero", 32'(beat_cnt), 32'h0);
        in_valid = 1'b0;
        edge_step();

`ifdef DECODER_PARITY_CHK_EN
        rst = 1'b1;
        #2 rst = 1'b0;
        edge_step();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_en = 1'b1;
            in_code = enc8x3(sweep_exp[k]);
            edge_step();
            check($sformatf("rt_out_%0d", k), 32'(out), 32'(sweep_exp[k]));
            check($sformatf("rt_par_err_%0d", k), 32'(par_err), 32'h0);
        end
        in_valid = 1'b0;
        edge_step();
        check("rt_cnt", 32'(beat_cnt), 32'd8);
        in_valid = 1'b1; in_code = 3'd2; corrupt = 1'b1;
        edge_step();
        check("par_err_pulse", 32'(par_err), 32'h1);
        check("par_drop_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b0; corrupt = 1'b0;
        edge_step();
        check("par_err_clear", 32'(par_err), 32'h0);
        check("par_drop_cnt", 32'(beat_cnt), 32'd8);
        check("par_drop_valid2", 32'(out_valid), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
